// File: rtl/evict_wb_buffer_pkg.sv
// evict_wb_buffer_pkg: shared types and helpers for the victim/write-back buffer
package evict_wb_buffer_pkg;
  localparam int LC3B_LINE_OFFSET_BITS = 4;
  localparam int LC3B_ADDR_WIDTH = 16;
  typedef logic [LC3B_ADDR_WIDTH-LC3B_LINE_OFFSET_BITS-1:0] lc3b_wb_tag;
  typedef enum logic [1:0] {WB_IDLE, WB_WRITE, WB_DONE} lc3b_wb_state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/evict_wb_buffer_lru.sv
// evict_lru_tracker: true-LRU age matrix with masked oldest-entry selection
//   touch_young/touch_old: per-entry masks applied at the clock edge
//   clean_mask/dirty_mask -> oldest_clean/oldest_dirty (lowest index if mask empty)
module evict_lru_tracker #(
  parameter int ENTRIES = 4,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ENTRIES-1:0] touch_young,
  input  logic [ENTRIES-1:0] touch_old,
  input  logic [ENTRIES-1:0] clean_mask,
  input  logic [ENTRIES-1:0] dirty_mask,
  output logic [IW-1:0]      oldest_clean,
  output logic [IW-1:0]      oldest_dirty
);
  // older[i][j] set means entry i is older than entry j
  logic [ENTRIES-1:0] older [ENTRIES];
  logic [ENTRIES-1:0] older_nxt [ENTRIES];
  always_comb begin
    for (int i = 0; i < ENTRIES; i++)
      for (int j = 0; j < ENTRIES; j++)
        older_nxt[i][j] = (touch_young[j] & ~touch_young[i]) ? 1'b1 :
                          (touch_young[i] & ~touch_young[j]) ? 1'b0 :
                          (touch_old[i] & ~touch_old[j])     ? 1'b1 :
                          (touch_old[j] & ~touch_old[i])     ? 1'b0 : older[i][j];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        for (int j = 0; j < ENTRIES; j++)
          older[i][j] <= (i < j);
    end else begin
      older <= older_nxt;
    end
  // An entry is oldest within a mask when it is older than every other masked entry
  function automatic logic [IW-1:0] pick(input logic [ENTRIES-1:0] m);
    pick = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (m[i] && &(older[i] | ~m | (ENTRIES'(1) << i))) pick = IW'(i);
  endfunction
  assign oldest_clean = pick(clean_mask);
  assign oldest_dirty = pick(dirty_mask);
endmodule

// File: rtl/evict_wb_buffer.sv
// evict_wb_buffer: fully-associative victim/write-back buffer with LRU and drain FSM
//   insert: in_valid/in_ready/in_addr/in_data/in_dirty
//   lookup: lkp_addr/lkp_take -> lkp_hit/lkp_data (combinational)
//   drain : pmem_write/pmem_address/pmem_wdata/pmem_resp
//   status: occupancy (registered valid count)
//   EVICT_WB_PERF_EN adds saturating perf_hits/perf_inserts/perf_drains/perf_stall_cycles
module evict_wb_buffer
  import evict_wb_buffer_pkg::*;
#(
  parameter int ENTRIES      = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_WIDTH   = 128,
  parameter int OFFSET_BITS  = LC3B_LINE_OFFSET_BITS,
  parameter int DRAIN_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_addr,
  input  logic [LINE_WIDTH-1:0]      in_data,
  input  logic                       in_dirty,
  input  logic [ADDR_WIDTH-1:0]      lkp_addr,
  input  logic                       lkp_take,
  output logic                       lkp_hit,
  output logic [LINE_WIDTH-1:0]      lkp_data,
  output logic                       pmem_write,
  output logic [ADDR_WIDTH-1:0]      pmem_address,
  output logic [LINE_WIDTH-1:0]      pmem_wdata,
  input  logic                       pmem_resp,
  output logic [$clog2(ENTRIES):0]   occupancy
`ifdef EVICT_WB_PERF_EN
  ,
  output logic [31:0]                perf_hits,
  output logic [31:0]                perf_inserts,
  output logic [31:0]                perf_drains,
  output logic [31:0]                perf_stall_cycles
`endif
);
  localparam int IW = $clog2(ENTRIES);
  localparam int CW = IW + 1;
  localparam int TW = ADDR_WIDTH - OFFSET_BITS;
  logic [TW-1:0]         tags [ENTRIES];
  logic [LINE_WIDTH-1:0] data [ENTRIES];
  logic [ENTRIES-1:0]    valid, dirty, valid_nxt, dirty_nxt, lkp_match, in_match, young, old;
  logic [IW-1:0]         lkp_idx, hit_idx, free_idx, ins_idx, lru_clean, lru_dirty, drain_idx;
  logic [CW-1:0]         dirty_cnt, occ_nxt;
  logic                  ins_fire, take_fire, start, redirty;
  lc3b_wb_state_t        state, state_nxt;
  logic                  unused_offsets;
  assign unused_offsets = ^{in_addr[OFFSET_BITS-1:0], lkp_addr[OFFSET_BITS-1:0]};
  always_comb begin
    lkp_match = '0;
    in_match  = '0;
    lkp_idx   = '0;
    hit_idx   = '0;
    free_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      lkp_match[i] = valid[i] && tags[i] == lkp_addr[ADDR_WIDTH-1:OFFSET_BITS];
      in_match[i]  = valid[i] && tags[i] == in_addr[ADDR_WIDTH-1:OFFSET_BITS];
      if (lkp_match[i]) lkp_idx = IW'(i);
      if (in_match[i]) hit_idx = IW'(i);
      if (!valid[i]) free_idx = IW'(i);
    end
  end
  assign lkp_hit   = |lkp_match;
  assign lkp_data  = lkp_hit ? data[lkp_idx] : '0;
  assign in_ready  = ~&(valid & dirty);
  assign ins_fire  = in_valid & in_ready;
  assign ins_idx   = |in_match ? hit_idx : ~&valid ? free_idx : lru_clean;
  // A concurrent insert to the looked-up entry wins over the take
  assign take_fire = lkp_hit & lkp_take & ~(ins_fire & ins_idx == lkp_idx);
  assign young     = (ins_fire ? ENTRIES'(1) << ins_idx : '0) |
                     (lkp_hit & ~lkp_take ? ENTRIES'(1) << lkp_idx : '0);
  assign old       = take_fire ? ENTRIES'(1) << lkp_idx : '0;
  assign start     = state == WB_IDLE && (dirty_cnt >= CW'(DRAIN_THRESH) || !in_ready);
  assign pmem_write = state == WB_WRITE;
  assign state_nxt = state == WB_IDLE  ? (start ? WB_WRITE : WB_IDLE) :
                     state == WB_WRITE ? (pmem_resp ? WB_DONE : WB_WRITE) : WB_IDLE;
  // Insert is applied last so it overrides both a take and the post-drain clear
  always_comb begin
    valid_nxt = valid;
    dirty_nxt = dirty;
    if (take_fire) begin
      valid_nxt[lkp_idx] = 1'b0;
      dirty_nxt[lkp_idx] = 1'b0;
    end
    if (state == WB_DONE && !redirty) dirty_nxt[drain_idx] = 1'b0;
    if (ins_fire) begin
      valid_nxt[ins_idx] = 1'b1;
      dirty_nxt[ins_idx] = dirty[ins_idx] | in_dirty;
    end
    dirty_cnt = '0;
    occ_nxt   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      dirty_cnt = dirty_cnt + CW'(valid[i] & dirty[i]);
      occ_nxt   = occ_nxt + CW'(valid_nxt[i]);
    end
  end
  evict_lru_tracker #(.ENTRIES(ENTRIES)) u_lru (
    .clk          (clk),
    .rst_n        (rst_n),
    .touch_young  (young),
    .touch_old    (old),
    .clean_mask   (valid & ~dirty),
    .dirty_mask   (valid & dirty),
    .oldest_clean (lru_clean),
    .oldest_dirty (lru_dirty)
  );
  always_ff @(posedge clk)
    if (ins_fire) begin
      tags[ins_idx] <= in_addr[ADDR_WIDTH-1:OFFSET_BITS];
      data[ins_idx] <= in_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= WB_IDLE;
      valid        <= '0;
      dirty        <= '0;
      occupancy    <= '0;
      drain_idx    <= '0;
      redirty      <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      state     <= state_nxt;
      valid     <= valid_nxt;
      dirty     <= dirty_nxt;
      occupancy <= occ_nxt;
      if (start) begin
        drain_idx    <= lru_dirty;
        pmem_address <= {tags[lru_dirty], OFFSET_BITS'(0)};
        pmem_wdata   <= data[lru_dirty];
      end
      // Any write into the entry being drained keeps it dirty after the drain
      redirty <= (state == WB_WRITE && redirty) ||
                 ((start || state == WB_WRITE) && ins_fire && ins_idx == (start ? lru_dirty : drain_idx));
    end
`ifdef EVICT_WB_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_hits         <= '0;
      perf_inserts      <= '0;
      perf_drains       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_hits         <= sat_inc(perf_hits, lkp_hit);
      perf_inserts      <= sat_inc(perf_inserts, ins_fire);
      perf_drains       <= sat_inc(perf_drains, start);
      perf_stall_cycles <= sat_inc(perf_stall_cycles, in_valid & ~in_ready);
    end
`endif
endmodule

// File: tb/tb_evict_wb_buffer.sv
// tb_evict_wb_buffer: scoreboard bench for evict_wb_buffer
module tb_evict_wb_buffer;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam logic [AW-1:0] IDLE_A = 16'hFFF0;
  logic clk = 0, rst_n = 0, in_valid = 0, in_dirty = 0, lkp_take = 0, pmem_resp = 0;
  logic in_ready, lkp_hit, pmem_write;
  logic [AW-1:0] in_addr = '0, lkp_addr = IDLE_A, pmem_address;
  logic [LW-1:0] in_data = '0, lkp_data, pmem_wdata;
  logic [2:0] occupancy;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int cyc; int f; logic [LW-1:0] v;} exp_t;
  typedef struct {logic [AW-1:0] a; logic [LW-1:0] d;} drn_t;
  exp_t exp_q[$];
  drn_t drn_q[$];
  evict_wb_buffer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_dirty(in_dirty), .lkp_addr(lkp_addr), .lkp_take(lkp_take),
    .lkp_hit(lkp_hit), .lkp_data(lkp_data), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end
  function automatic logic [LW-1:0] pat(input logic [31:0] n);
    return {n, ~n, n ^ 32'h5a5a_a5a5, n + 32'd1};
  endfunction
  function automatic string fname(input int f);
    case (f)
      0: return "lkp_hit";
      1: return "lkp_data";
      2: return "occupancy";
      3: return "in_ready";
      4: return "pmem_write";
      5: return "pmem_address";
      default: return "pmem_wdata";
    endcase
  endfunction
  function automatic logic [LW-1:0] probe(input int f);
    case (f)
      0: return LW'(lkp_hit);
      1: return lkp_data;
      2: return LW'(occupancy);
      3: return LW'(in_ready);
      4: return LW'(pmem_write);
      5: return LW'(pmem_address);
      default: return pmem_wdata;
    endcase
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input int f, input logic [LW-1:0] v);
    exp_q.push_back('{cyc, f, v});
  endtask
  task automatic drain_exp(input logic [AW-1:0] a, input logic [LW-1:0] d);
    drn_q.push_back('{a, d});
  endtask
  task automatic ins(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic dr);
    in_valid = 1; in_addr = a; in_data = d; in_dirty = dr;
    tick();
    in_valid = 0; in_dirty = 0;
  endtask
  task automatic respond();
    int n = 0;
    while (!pmem_write && n < 20) begin tick(); n++; end
    if (!pmem_write) begin
      checks++; errors++;
      $display("FAIL drain_wait cyc=%0d got=no_write exp=write", cyc);
    end
    pmem_resp = 1;
    tick();
    pmem_resp = 0;
    tick();
  endtask
  task automatic reset_dut();
    in_valid = 0; lkp_take = 0; pmem_resp = 0; lkp_addr = IDLE_A; rst_n = 0;
    tick();
    chk(4, 0); chk(5, 0); chk(6, 0); chk(2, 0); chk(3, 1); chk(0, 0);
    tick();
    rst_n = 1;
    tick();
  endtask
  // Monitor: time-stamped output expectations and drain transactions
  exp_t e;
  drn_t d;
  logic pw_q = 0;
  logic [AW-1:0] ha;
  logic [LW-1:0] hd;
  logic [LW-1:0] got;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      got = probe(e.f);
      checks++;
      if (e.cyc != cyc || got !== e.v) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", fname(e.f), cyc, got, e.v);
      end
    end
    if (pmem_write && !pw_q) begin
      checks++;
      if (drn_q.size() == 0) begin
        errors++;
        $display("FAIL drain_unexpected cyc=%0d got=%0h exp=none", cyc, pmem_address);
        ha = pmem_address; hd = pmem_wdata;
      end else begin
        d = drn_q.pop_front();
        ha = d.a; hd = d.d;
        if (pmem_address !== d.a || pmem_wdata !== d.d) begin
          errors++;
          $display("FAIL drain_start cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, pmem_address, pmem_wdata, d.a, d.d);
        end
      end
    end else if (pmem_write) begin
      checks++;
      if (pmem_address !== ha || pmem_wdata !== hd) begin
        errors++;
        $display("FAIL drain_hold cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, pmem_address, pmem_wdata, ha, hd);
      end
    end
    pw_q = pmem_write;
  end
  initial begin
    // Basic insert/lookup, then two dirty lines trigger drains
    reset_dut();
    ins(16'h1230, pat(1), 0);
    lkp_addr = 16'h1234;
    chk(0, 1); chk(1, pat(1)); chk(2, 1); chk(4, 0);
    tick();
    lkp_addr = IDLE_A;
    drain_exp(16'h1000, pat(2));
    ins(16'h1000, pat(2), 1);
    ins(16'h2000, pat(3), 1);
    chk(4, 0);
    tick();
    chk(4, 1); chk(5, 16'h1000);
    respond();
    chk(2, 3); chk(4, 0);
    drain_exp(16'h2000, pat(3));
    ins(16'h3000, pat(4), 1);
    respond();
    chk(2, 4); chk(3, 1);
    tick();
    // All-dirty back-pressure and replacement of the drained line
    reset_dut();
    drain_exp(16'hA000, pat(10));
    ins(16'hA000, pat(10), 1);
    ins(16'hB000, pat(11), 1);
    ins(16'hC000, pat(12), 1);
    ins(16'hD000, pat(13), 1);
    in_valid = 1; in_addr = 16'hE000; in_data = pat(14); in_dirty = 0;
    chk(3, 0); chk(2, 4);
    tick();
    chk(3, 0);
    tick();
    pmem_resp = 1;
    chk(3, 0); chk(4, 1);
    tick();
    pmem_resp = 0;
    chk(3, 0); chk(4, 0);
    tick();
    chk(3, 1);
    drain_exp(16'hB000, pat(11));
    tick();
    in_valid = 0;
    lkp_addr = 16'hE000;
    chk(0, 1); chk(1, pat(14));
    tick();
    lkp_addr = 16'hA000;
    chk(0, 0); chk(1, 0);
    tick();
    lkp_addr = IDLE_A;
    drain_exp(16'hC000, pat(12));
    respond();
    respond();
    // Insert into the line being drained: redirty and later redrain with new data
    reset_dut();
    drain_exp(16'h1000, pat(1));
    ins(16'h1000, pat(1), 1);
    ins(16'h2000, pat(2), 1);
    tick();
    chk(4, 1);
    in_valid = 1; in_addr = 16'h1000; in_data = pat(21); in_dirty = 0;
    tick();
    in_valid = 0;
    lkp_addr = 16'h1000;
    chk(6, pat(1)); chk(1, pat(21));
    tick();
    lkp_addr = IDLE_A;
    drain_exp(16'h2000, pat(2));
    respond();
    respond();
    chk(2, 2);
    drain_exp(16'h1000, pat(21));
    ins(16'h3000, pat(3), 1);
    respond();
    // Take racing an insert to the same line, then a plain take
    reset_dut();
    ins(16'h3000, pat(5), 0);
    in_valid = 1; in_addr = 16'h3000; in_data = pat(6);
    lkp_addr = 16'h3000; lkp_take = 1;
    chk(0, 1); chk(1, pat(5));
    tick();
    in_valid = 0; lkp_take = 0;
    chk(0, 1); chk(1, pat(6)); chk(2, 1);
    lkp_take = 1;
    tick();
    lkp_take = 0;
    chk(0, 0); chk(1, 0); chk(2, 0);
    tick();
    lkp_addr = IDLE_A;
    // LRU replacement among clean lines
    reset_dut();
    ins(16'h0000, pat(30), 0);
    ins(16'h0010, pat(31), 0);
    ins(16'h0020, pat(32), 0);
    ins(16'h0030, pat(33), 0);
    lkp_addr = 16'h0000;
    chk(0, 1);
    tick();
    lkp_addr = IDLE_A;
    ins(16'h0040, pat(34), 0);
    lkp_addr = 16'h0010;
    chk(0, 0);
    tick();
    lkp_addr = 16'h0000;
    chk(0, 1); chk(1, pat(30));
    tick();
    lkp_addr = 16'h0040;
    chk(0, 1); chk(1, pat(34)); chk(2, 4);
    tick();
    lkp_addr = IDLE_A;
    // Asynchronous reset in the middle of a drain
    reset_dut();
    drain_exp(16'h5000, pat(40));
    ins(16'h5000, pat(40), 1);
    ins(16'h6000, pat(41), 1);
    tick();
    chk(4, 1);
    tick();
    rst_n = 0;
    #1;
    chk(4, 0); chk(2, 0); chk(3, 1);
    tick();
    rst_n = 1;
    repeat (5) tick();
    chk(4, 0); chk(2, 0);
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || drn_q.size() != 0) begin
      errors++;
      $display("FAIL queues_empty got=%0d/%0d exp=0/0", exp_q.size(), drn_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
